pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised fetch-PC generator, successor of the single-step PC register. It holds the fetch PC and resolves stall and redirect priority. It adds an internal direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so next-PC prediction is made in-block rather than supplied externally. It sits at the head of the fetch stage, is fed by the stall controller and the EX-stage branch resolver, and drives the instruction-fetch address.

## Interface
Parameters:
- ADDR_W, 32, PC / target width in bits.
- RESET_PC, 0, PC value loaded on reset.
- INST_BYTES, 4, fetch step in bytes; power of two, at least 2.
- BTB_DEPTH, 16, BTB entries; power of two, at least 2.
- Derived: OFS_W = log2(INST_BYTES), IDX_W = log2(BTB_DEPTH), TAG_W = ADDR_W - IDX_W - OFS_W.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset; one clock, synchronous and active-low (rst==0 resets on the clk edge).
- rdy  in  1  global ready; 0 freezes all state.
- stall_hold  in  1  back-end hold; PC frozen, redirect ignored.
- stall_fetch  in  1  fetch stall; PC frozen unless redirected.
- ex_redirect  in  1  EX mispredict; load ex_redirect_target.
- ex_redirect_target  in  ADDR_W  corrected PC.
- ex_upd_valid  in  1  resolved-branch update strobe.
- ex_upd_pc  in  ADDR_W  PC of the resolved branch.
- ex_upd_taken  in  1  actual direction.
- ex_upd_target  in  ADDR_W  actual taken target.
- pc  out  ADDR_W  current fetch PC.
- jmp  out  1  1 when pc was reached by a predicted-taken jump.
- pred_taken  out  1  combinational: the instruction at pc is predicted taken.
- pred_target  out  ADDR_W  combinational: predicted target for pc; equals pc+INST_BYTES when pred_taken is 0.
- redirect_cnt  out  16  saturating count of accepted redirects.

## Operation
- BTB entry fields: valid, tag[TAG_W], target[ADDR_W], ctr[2].
- Index = addr[OFS_W+IDX_W-1:OFS_W]; tag = addr[ADDR_W-1:OFS_W+IDX_W].
- Lookup on pc: hit = valid & tag match; pred_taken = hit & ctr[1]; pred_target = target on pred_taken, else pc+INST_BYTES.
- PC update priority, highest first:
  1. rst==0: pc<=RESET_PC, jmp<=0, redirect_cnt<=0, all valid<=0, all ctr<=2'b01.
  2. rdy==0: hold all state; no BTB write.
  3. stall_hold: hold pc and jmp.
  4. ex_redirect: pc<=ex_redirect_target, jmp<=0, redirect_cnt increments, saturating at 16'hFFFF.
  5. stall_fetch: hold pc and jmp.
  6. pred_taken: pc<=pred_target, jmp<=1.
  7. Otherwise: pc<=pc+INST_BYTES modulo 2^ADDR_W, jmp<=0.
- BTB update, when rdy=1 and rst=1 and ex_upd_valid=1, independent of stalls, using the index and tag of ex_upd_pc:
  - Hit, taken: ctr saturating increment (max 2'b11); target<=ex_upd_target.
  - Hit, not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate and overwrite the entry: valid<=1, new tag, target<=ex_upd_target, ctr<=2'b10.
  - Miss, not taken: no change.
- ex_redirect and ex_upd_valid are independent; both may fire in the same cycle.
- Targets are used unaligned-as-given; no masking of offset bits.

## Timing
- Fetch PC update: one cycle from the input edge to the new pc.
- Prediction: lookup is zero-latency combinational on the registered BTB.
- BTB write is visible to lookup on the cycle after the write edge. A same-cycle lookup of the entry being written sees the old contents.
- A redirect during stall_hold is dropped. EX must hold ex_redirect until the hold releases.
- Aliasing: two PCs with the same index evict each other, last taken writer wins.
- Reset outputs: pc=RESET_PC, jmp=0, redirect_cnt=0, pred_taken=0, pred_target=RESET_PC+INST_BYTES.
- Reset asserted mid-stall or mid-update overrides everything on that edge.

## Test plan
- Reset then free-run with defaults: pc sequence 0,4,8,C; jmp=0; pred_taken=0.
- Update pc=0x10, taken, target=0x40; rerun from 0: pc 0,4,8,C,0x10,0x40 with jmp=1 at 0x40. Then two not-taken updates for 0x10 drop ctr 10 to 01 to 00: next pass 0x10 goes to 0x14.
- Same cycle ex_redirect=1 (target 0x100) and stall_fetch=1: pc=0x100, redirect_cnt=1. Same with stall_hold=1: pc held, redirect_cnt=0.
- Alias, BTB_DEPTH=16: taken 0x10 to 0x40, then taken 0x50 to 0x80 (same index 4). Lookup at 0x10 misses; lookup at 0x50 predicts 0x80.
- rdy=0 for 3 cycles with ex_upd_valid pulsed: pc, BTB and counter all unchanged. Wrap test, ADDR_W=8: pc 0xFC steps to 0x00.
- Redirect counter: 65540 back-to-back redirects leave redirect_cnt=16'hFFFF; rst=0 for one edge gives all outputs their reset values.

Source files
------------

// File: rtl/pc_gen_if.sv
// Fetch-PC generator bus: stall/redirect/BTB-update inputs and fetch-address outputs.
interface pc_gen_if #(
  parameter int ADDR_W = 32
);
  logic              rdy;
  logic              stall_hold;
  logic              stall_fetch;
  logic              ex_redirect;
  logic [ADDR_W-1:0] ex_redirect_target;
  logic              ex_upd_valid;
  logic [ADDR_W-1:0] ex_upd_pc;
  logic              ex_upd_taken;
  logic [ADDR_W-1:0] ex_upd_target;
  logic [ADDR_W-1:0] pc;
  logic              jmp;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic [15:0]       redirect_cnt;

  // Controller side: stall controller and EX branch resolver.
  modport master (
    output rdy, stall_hold, stall_fetch, ex_redirect, ex_redirect_target,
           ex_upd_valid, ex_upd_pc, ex_upd_taken, ex_upd_target,
    input  pc, jmp, pred_taken, pred_target, redirect_cnt
  );

  // PC generator side.
  modport slave (
    input  rdy, stall_hold, stall_fetch, ex_redirect, ex_redirect_target,
           ex_upd_valid, ex_upd_pc, ex_upd_taken, ex_upd_target,
    output pc, jmp, pred_taken, pred_target, redirect_cnt
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch-PC generator with an internal direct-mapped BTB of 2-bit saturating
// counters. Resolves reset/ready/stall/redirect/prediction priority each cycle.
module pc_gen #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                INST_BYTES = 4,
  parameter int                BTB_DEPTH  = 16
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);
  localparam int OFS_W = $clog2(INST_BYTES);
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - OFS_W;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_BYTES);

  logic              valid_q  [BTB_DEPTH];
  logic [TAG_W-1:0]  tag_q    [BTB_DEPTH];
  logic [ADDR_W-1:0] target_q [BTB_DEPTH];
  logic [1:0]        ctr_q    [BTB_DEPTH];

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              jmp_q, jmp_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] pred_target;

  logic [IDX_W-1:0]  up_idx;
  logic [TAG_W-1:0]  up_tag;
  logic              up_hit;
  logic              btb_we;
  logic              wr_valid;
  logic [TAG_W-1:0]  wr_tag;
  logic [ADDR_W-1:0] wr_target;
  logic [1:0]        wr_ctr;

  // Offset bits of the update PC never select an entry; only the index/tag matter.
  logic unused_upd_ofs;
  assign unused_upd_ofs = ^bus.ex_upd_pc[OFS_W-1:0];

  // Zero-latency lookup on the registered BTB for the current fetch PC.
  assign lk_idx      = pc_q[OFS_W+IDX_W-1:OFS_W];
  assign lk_tag      = pc_q[ADDR_W-1:OFS_W+IDX_W];
  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
  assign seq_pc      = pc_q + STEP;
  assign pred_target = pred_taken ? target_q[lk_idx] : seq_pc;

  assign up_idx = bus.ex_upd_pc[OFS_W+IDX_W-1:OFS_W];
  assign up_tag = bus.ex_upd_pc[ADDR_W-1:OFS_W+IDX_W];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  assign bus.pc           = pc_q;
  assign bus.jmp          = jmp_q;
  assign bus.pred_taken   = pred_taken;
  assign bus.pred_target  = pred_target;
  assign bus.redirect_cnt = cnt_q;

  // Next fetch PC: ready gates everything, then hold, redirect, fetch stall, prediction, step.
  always_comb begin
    pc_d  = pc_q;
    jmp_d = jmp_q;
    cnt_d = cnt_q;
    if (bus.rdy) begin
      if (bus.stall_hold) begin
        pc_d  = pc_q;
      end else if (bus.ex_redirect) begin
        pc_d  = bus.ex_redirect_target;
        jmp_d = 1'b0;
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end else if (bus.stall_fetch) begin
        pc_d  = pc_q;
      end else if (pred_taken) begin
        pc_d  = pred_target;
        jmp_d = 1'b1;
      end else begin
        pc_d  = seq_pc;
        jmp_d = 1'b0;
      end
    end
  end

  // BTB write for a resolved branch: train on hit, allocate only on a taken miss.
  always_comb begin
    btb_we    = 1'b0;
    wr_valid  = valid_q[up_idx];
    wr_tag    = tag_q[up_idx];
    wr_target = target_q[up_idx];
    wr_ctr    = ctr_q[up_idx];
    if (bus.rdy && bus.ex_upd_valid) begin
      if (up_hit) begin
        btb_we = 1'b1;
        if (bus.ex_upd_taken) begin
          wr_target = bus.ex_upd_target;
          if (ctr_q[up_idx] != 2'b11) begin
            wr_ctr = ctr_q[up_idx] + 2'd1;
          end
        end else if (ctr_q[up_idx] != 2'b00) begin
          wr_ctr = ctr_q[up_idx] - 2'd1;
        end
      end else if (bus.ex_upd_taken) begin
        btb_we    = 1'b1;
        wr_valid  = 1'b1;
        wr_tag    = up_tag;
        wr_target = bus.ex_upd_target;
        wr_ctr    = 2'b10;
      end
    end
  end

  // PC, jump flag and redirect counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q  <= RESET_PC;
      jmp_q <= 1'b0;
      cnt_q <= 16'd0;
    end else begin
      pc_q  <= pc_d;
      jmp_q <= jmp_d;
      cnt_q <= cnt_d;
    end
  end

  // BTB storage; reset invalidates every entry and weakens every counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (btb_we) begin
      valid_q[up_idx]  <= wr_valid;
      tag_q[up_idx]    <= wr_tag;
      target_q[up_idx] <= wr_target;
      ctr_q[up_idx]    <= wr_ctr;
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed stimulus pushes expected outputs,
// a negedge monitor pops and compares them when they come due.
module tb_pc_gen;
  logic clk;
  logic rst;
  int   cycleCnt;
  int   checks;
  int   errors;

  typedef struct packed {
    int          due;
    logic        narrow;
    logic [31:0] pc;
    logic        jmp;
    logic        pt;
    logic [31:0] ptgt;
    logic [15:0] cnt;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];
  exp_t  curExp;
  string curName;

  pc_gen_if #(.ADDR_W(32)) busW ();
  pc_gen_if #(.ADDR_W(8))  busN ();

  pc_gen #(.ADDR_W(32), .RESET_PC(32'h0), .INST_BYTES(4), .BTB_DEPTH(16)) dutW (
    .clk (clk),
    .rst (rst),
    .bus (busW)
  );

  pc_gen #(.ADDR_W(8), .RESET_PC(8'hFC), .INST_BYTES(4), .BTB_DEPTH(16)) dutN (
    .clk (clk),
    .rst (rst),
    .bus (busN)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to schedule when each expectation becomes due.
  initial cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Drive one cycle of inputs just after the active edge; consumed at the next edge.
  task automatic applyStimulus(input logic rstN, input logic rdy, input logic sh,
                               input logic sf, input logic red, input logic [31:0] redT,
                               input logic uv, input logic [31:0] upc, input logic ut,
                               input logic [31:0] utgt);
    @(posedge clk);
    #1;
    rst                     = rstN;
    busW.rdy                = rdy;
    busW.stall_hold         = sh;
    busW.stall_fetch        = sf;
    busW.ex_redirect        = red;
    busW.ex_redirect_target = redT;
    busW.ex_upd_valid       = uv;
    busW.ex_upd_pc          = upc;
    busW.ex_upd_taken       = ut;
    busW.ex_upd_target      = utgt;
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic update(input logic [31:0] upc, input logic ut, input logic [31:0] utgt);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, upc, ut, utgt);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, tgt, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Queue the wide DUT's expected outputs after the edge that consumes the current stimulus.
  task automatic checkOutput(input string name, input logic [31:0] pc, input logic jmp,
                             input logic pt, input logic [31:0] ptgt, input logic [15:0] cnt);
    exp_t e;
    e.due = cycleCnt + 1; e.narrow = 1'b0; e.pc = pc; e.jmp = jmp;
    e.pt = pt; e.ptgt = ptgt; e.cnt = cnt;
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  // Queue the 8-bit DUT's expected pc after the same edge.
  task automatic checkNarrow(input string name, input logic [7:0] pc);
    exp_t e;
    e.due = cycleCnt + 1; e.narrow = 1'b1; e.pc = {24'h0, pc}; e.jmp = 1'b0;
    e.pt = 1'b0; e.ptgt = 32'h0; e.cnt = 16'h0;
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  // Monitor: pop every expectation due at this cycle and compare against the DUT.
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].due <= cycleCnt) begin
      curExp  = expQ.pop_front();
      curName = nameQ.pop_front();
      checks  = checks + 1;
      if (curExp.due != cycleCnt) begin
        errors = errors + 1;
        $display("[TB] FAIL %s: expectation missed, due cycle %0d seen at %0d",
                 curName, curExp.due, cycleCnt);
      end else if (curExp.narrow) begin
        if (busN.pc !== curExp.pc[7:0]) begin
          errors = errors + 1;
          $display("[TB] FAIL %s: pc=%h expected %h", curName, busN.pc, curExp.pc[7:0]);
        end
      end else if (busW.pc !== curExp.pc || busW.jmp !== curExp.jmp ||
                   busW.pred_taken !== curExp.pt || busW.pred_target !== curExp.ptgt ||
                   busW.redirect_cnt !== curExp.cnt) begin
        errors = errors + 1;
        $display("[TB] FAIL %s: got pc=%h jmp=%b pt=%b ptgt=%h cnt=%h expected pc=%h jmp=%b pt=%b ptgt=%h cnt=%h",
                 curName, busW.pc, busW.jmp, busW.pred_taken, busW.pred_target, busW.redirect_cnt,
                 curExp.pc, curExp.jmp, curExp.pt, curExp.ptgt, curExp.cnt);
      end
    end
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    busW.rdy = 1'b1; busW.stall_hold = 1'b0; busW.stall_fetch = 1'b0;
    busW.ex_redirect = 1'b0; busW.ex_redirect_target = 32'h0;
    busW.ex_upd_valid = 1'b0; busW.ex_upd_pc = 32'h0;
    busW.ex_upd_taken = 1'b0; busW.ex_upd_target = 32'h0;
    busN.rdy = 1'b1; busN.stall_hold = 1'b0; busN.stall_fetch = 1'b0;
    busN.ex_redirect = 1'b0; busN.ex_redirect_target = 8'h0;
    busN.ex_upd_valid = 1'b0; busN.ex_upd_pc = 8'h0;
    busN.ex_upd_taken = 1'b0; busN.ex_upd_target = 8'h0;

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("reset", 32'h0, 1'b0, 1'b0, 32'h4, 16'h0);
    checkNarrow("narrow_reset", 8'hFC);

    update(32'h10, 1'b1, 32'h40);
    checkOutput("step4_alloc", 32'h4, 1'b0, 1'b0, 32'h8, 16'h0);
    checkNarrow("narrow_wrap", 8'h00);
    idle();
    checkOutput("step8", 32'h8, 1'b0, 1'b0, 32'hC, 16'h0);
    checkNarrow("narrow_step", 8'h04);
    idle();
    checkOutput("stepC", 32'hC, 1'b0, 1'b0, 32'h10, 16'h0);
    idle();
    checkOutput("predict_at_10", 32'h10, 1'b0, 1'b1, 32'h40, 16'h0);
    idle();
    checkOutput("jump_to_40", 32'h40, 1'b1, 1'b0, 32'h44, 16'h0);
    idle();
    checkOutput("after_jump", 32'h44, 1'b0, 1'b0, 32'h48, 16'h0);

    update(32'h10, 1'b0, 32'h0);
    checkOutput("nt1", 32'h48, 1'b0, 1'b0, 32'h4C, 16'h0);
    update(32'h10, 1'b0, 32'h0);
    checkOutput("nt2", 32'h4C, 1'b0, 1'b0, 32'h50, 16'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h10, 1'b0, 32'h0);
    checkOutput("ctr_floor_redirect", 32'h10, 1'b0, 1'b0, 32'h14, 16'h1);
    update(32'h10, 1'b1, 32'h40);
    checkOutput("weak_inc", 32'h14, 1'b0, 1'b0, 32'h18, 16'h1);
    redirect(32'h10);
    checkOutput("still_not_taken", 32'h10, 1'b0, 1'b0, 32'h14, 16'h2);
    update(32'h10, 1'b1, 32'h60);
    checkOutput("retarget", 32'h14, 1'b0, 1'b0, 32'h18, 16'h2);
    redirect(32'h10);
    checkOutput("new_target", 32'h10, 1'b0, 1'b1, 32'h60, 16'h3);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("redirect_over_fetch_stall", 32'h100, 1'b0, 1'b0, 32'h104, 16'h4);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("hold_drops_redirect", 32'h100, 1'b0, 1'b0, 32'h104, 16'h4);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("fetch_stall", 32'h100, 1'b0, 1'b0, 32'h104, 16'h4);

    update(32'h50, 1'b1, 32'h80);
    checkOutput("alias_alloc", 32'h104, 1'b0, 1'b0, 32'h108, 16'h4);
    redirect(32'h10);
    checkOutput("alias_evicted", 32'h10, 1'b0, 1'b0, 32'h14, 16'h5);
    redirect(32'h50);
    checkOutput("alias_winner", 32'h50, 1'b0, 1'b1, 32'h80, 16'h6);
    idle();
    checkOutput("alias_jump", 32'h80, 1'b1, 1'b0, 32'h84, 16'h6);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h500, 1'b1, 32'h80, 1'b1, 32'h300);
      checkOutput("rdy_low_freeze", 32'h80, 1'b1, 1'b0, 32'h84, 16'h6);
    end
    idle();
    checkOutput("rdy_low_no_btb_write", 32'h84, 1'b0, 1'b0, 32'h88, 16'h6);

    for (int i = 0; i < 65540; i++) begin
      redirect(32'h0);
      if (i == 65527) checkOutput("cnt_fffe", 32'h0, 1'b0, 1'b0, 32'h4, 16'hFFFE);
      if (i == 65539) checkOutput("cnt_saturated", 32'h0, 1'b0, 1'b0, 32'h4, 16'hFFFF);
    end

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h900, 1'b1, 32'h0, 1'b1, 32'h700);
    checkOutput("reset_overrides", 32'h0, 1'b0, 1'b0, 32'h4, 16'h0);
    checkNarrow("narrow_reset_again", 8'hFC);
    redirect(32'h10);
    checkOutput("btb_cleared", 32'h10, 1'b0, 1'b0, 32'h14, 16'h1);
    redirect(32'h50);
    checkOutput("btb_cleared_alias", 32'h50, 1'b0, 1'b0, 32'h54, 16'h2);

    // Every expectation is due within one edge; a few spare cycles let the monitor drain.
    repeat (4) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
